wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//   Write-back stage: MEM/WB pipeline register plus write-back data selection. Sits directly
//   downstream of the data-memory stage and drives the register-file write port.
//   The data memory registers read data on the same edge that loads this block's register, so load
//   data is consumed live one cycle later. A hold register keeps it stable across pipeline freezes.
//   Also extracts and extends byte/half loads, and keeps a retired-instruction counter.
// PARAMETERS
//   WORD_LEN      32  datapath width (`WORD_LEN)
//   REG_ADDR_LEN   5  register-file address width (`REG_FILE_ADDR_LEN)
//   CNT_WIDTH     32  width of RETIRED_COUNT
// PORTS
//   CLK              in   1             clock, rising edge
//   RESET            in   1             asynchronous, active-low reset
//   FREEZE           in   1             hazard-unit stall; holds stage register
//   FLUSH            in   1             loads a bubble; has priority over FREEZE
//   WB_EN_IN         in   1             instruction in MEM writes a register
//   MEM_READ_EN      in   1             instruction in MEM is a load
//   LOAD_SIZE        in   2             00 word, 01 half, 10 byte, 11 reserved (treated as word)
//   LOAD_SIGNED      in   1             1 = sign-extend half/byte, 0 = zero-extend
//   DEST_IN          in   REG_ADDR_LEN  destination register
//   ALU_RESULT       in   WORD_LEN      ALU result / load address from MEM
//   DATA_MEMORY_OUT  in   WORD_LEN      registered data-memory read data, valid the cycle after capture
//   WB_EN            out  1             register-file write enable
//   WB_DEST          out  REG_ADDR_LEN  register-file write address
//   WB_VALUE         out  WORD_LEN      register-file write data (also the forwarding source)
//   LOAD_FAULT       out  1             misaligned load present in stage
//   RETIRED_COUNT    out  CNT_WIDTH     retired-instruction count, wraps
// BEHAVIOUR
//   - Reset (async, RESET=0):
//     - all stage fields and the hold register clear to 0; RETIRED_COUNT=0.
//     - Outputs: WB_EN=0, WB_DEST=0, WB_VALUE=0, LOAD_FAULT=0.
//     - Reset mid-instruction discards it; no write occurs.
//   - Stage register fields: valid, wb_en, mem_read, size, signed, dest, addr.
//   - Register update on each edge, first matching rule wins:
//     - FLUSH=1: bubble (valid=0, wb_en=0), hold_valid=0.
//     - FREEZE=1: all fields held.
//     - otherwise: capture the inputs, valid=1.
//   - Hold register:
//     - Edge with FREEZE=1, FLUSH=0, hold_valid=0: capture DATA_MEMORY_OUT, set hold_valid.
//     - Any edge with FREEZE=0 or FLUSH=1: clear hold_valid.
//     - Load source is hold_valid ? hold : DATA_MEMORY_OUT.
//   - Extraction (little-endian, off=addr[1:0]):
//     - word: data unchanged.
//     - half: lane data[16*off[1] +: 16].
//     - byte: lane data[8*off +: 8].
//     - Extend to WORD_LEN per the signed field.
//   - LOAD_FAULT = valid & mem_read & ((word & off!=0) | (half & off[0])). Combinational, 0 cycles.
//   - WB_VALUE = mem_read ? extracted : addr. This is combinational from the stage register.
//   - WB_EN = valid & wb_en & ~LOAD_FAULT & (dest!=0). R0 is never written.
//   - WB_DEST = dest.
//   - Latency: one edge from MEM inputs to WB outputs.
//   - WB_EN stays asserted while frozen (the rewrite of the same value is harmless).
//   - RETIRED_COUNT += 1 on an edge where valid & ~LOAD_FAULT & FREEZE=0 & FLUSH=0.
//     - Bubbles, flushed and faulted instructions are not counted.
//     - Wraps 2^CNT_WIDTH-1 -> 0.
//   - FLUSH and FREEZE together: the flush wins, the stage becomes empty and the count is not bumped.
// STRUCTURE
//   - defines.v: `WORD_LEN, `REG_FILE_ADDR_LEN, and the LOAD_SIZE encodings
//     `LOAD_WORD=2'b00, `LOAD_HALF=2'b01, `LOAD_BYTE=2'b10.
//   - Sub-module load_align: combinational (data, off, size, signed) -> extended word, plus a
//     misalign flag. Everything else stays in wb_stage.
// TESTING
//   1. Reset: hold RESET=0 mid-stream with WB_EN_IN=1 -> WB_EN=0, WB_VALUE=0, RETIRED_COUNT=0,
//      asynchronously (before the next edge).
//   2. ALU op: WB_EN_IN=1, DEST_IN=5, ALU_RESULT=0x1234_5678, MEM_READ_EN=0 -> next cycle WB_EN=1,
//      WB_DEST=5, WB_VALUE=0x1234_5678, RETIRED_COUNT=1.
//   3. Byte load: addr=0x...3, DATA_MEMORY_OUT=0x80FF_0011 -> signed WB_VALUE=0xFFFF_FF80,
//      unsigned 0x0000_0080. Half at off=2, signed -> 0xFFFF_80FF.
//   4. Freeze: load in stage, FREEZE=1 for 3 cycles, DATA_MEMORY_OUT changed to 0xDEAD_BEEF after the
//      first cycle -> WB_VALUE stays the original word, RETIRED_COUNT unchanged until FREEZE drops.
//   5. Misalign/R0: word load at addr 0x...2 -> LOAD_FAULT=1, WB_EN=0, no count.
//      ALU op with DEST_IN=0 -> WB_EN=0, count +1.
//   6. FLUSH+FREEZE same cycle with a valid op in stage -> next cycle WB_EN=0, no count.
//      Preset count 0xFFFF_FFFF + one retire -> 0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage: load-size encodings,
// stage control fields and the load misalignment rule.
package wb_stage_pkg;

    localparam int WORD_LEN_DEF     = 32;
    localparam int REG_ADDR_LEN_DEF = 5;
    localparam int CNT_WIDTH_DEF    = 32;

    typedef enum logic [1:0] {
        LOAD_WORD = 2'b00,
        LOAD_HALF = 2'b01,
        LOAD_BYTE = 2'b10,
        LOAD_RSVD = 2'b11
    } load_size_e;

    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_read;
        load_size_e size;
        logic       is_signed;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_CTRL_CLEAR = '{
        valid:     1'b0,
        wb_en:     1'b0,
        mem_read:  1'b0,
        size:      LOAD_WORD,
        is_signed: 1'b0
    };

    // The reserved encoding behaves as a word access, including its alignment rule.
    function automatic logic load_misaligned(input load_size_e size, input logic [1:0] off);
        logic mis;
        case (size)
            LOAD_HALF: mis = off[0];
            LOAD_BYTE: mis = 1'b0;
            default:   mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB bus: pipeline controls and instruction fields from the memory stage,
// plus the register-file write port and status driven by the write-back stage.
interface wb_stage_if #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int CNT_WIDTH    = 32
);
    logic                    FREEZE;
    logic                    FLUSH;
    logic                    WB_EN_IN;
    logic                    MEM_READ_EN;
    logic [1:0]              LOAD_SIZE;
    logic                    LOAD_SIGNED;
    logic [REG_ADDR_LEN-1:0] DEST_IN;
    logic [WORD_LEN-1:0]     ALU_RESULT;
    logic [WORD_LEN-1:0]     DATA_MEMORY_OUT;

    logic                    WB_EN;
    logic [REG_ADDR_LEN-1:0] WB_DEST;
    logic [WORD_LEN-1:0]     WB_VALUE;
    logic                    LOAD_FAULT;
    logic [CNT_WIDTH-1:0]    RETIRED_COUNT;

    modport master (
        output FREEZE, FLUSH, WB_EN_IN, MEM_READ_EN, LOAD_SIZE, LOAD_SIGNED,
               DEST_IN, ALU_RESULT, DATA_MEMORY_OUT,
        input  WB_EN, WB_DEST, WB_VALUE, LOAD_FAULT, RETIRED_COUNT
    );

    modport slave (
        input  FREEZE, FLUSH, WB_EN_IN, MEM_READ_EN, LOAD_SIZE, LOAD_SIGNED,
               DEST_IN, ALU_RESULT, DATA_MEMORY_OUT,
        output WB_EN, WB_DEST, WB_VALUE, LOAD_FAULT, RETIRED_COUNT
    );

endinterface

// File: rtl/wb_stage_load_align.sv
// Little-endian load lane extraction with sign/zero extension and a misalignment
// flag; purely combinational.
module wb_stage_load_align
    import wb_stage_pkg::*;
#(
    parameter int WORD_LEN = 32
) (
    input  logic [WORD_LEN-1:0] data,
    input  logic [1:0]          off,
    input  load_size_e          size,
    input  logic                is_signed,
    output logic [WORD_LEN-1:0] value,
    output logic                misalign
);

    logic [7:0]  byte_lane [4];
    logic [15:0] half_lane [2];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_lane[gi] = data[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_lane[gi] = data[16*gi +: 16];
        end
    endgenerate

    assign sel_byte = byte_lane[off];
    assign sel_half = half_lane[off[1]];

    always_comb begin
        value = data;
        case (size)
            LOAD_HALF: value = {{(WORD_LEN-16){is_signed & sel_half[15]}}, sel_half};
            LOAD_BYTE: value = {{(WORD_LEN-8){is_signed & sel_byte[7]}}, sel_byte};
            default:   value = data;
        endcase
    end

    assign misalign = load_misaligned(size, off);

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load-data hold across freezes, load alignment,
// register-file write selection and a retired-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int WORD_LEN     = WORD_LEN_DEF,
    parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input logic     CLK,
    input logic     RESET,
    wb_stage_if.slave bus
);

    stage_ctrl_t             ctrl_reg, ctrl_next;
    logic [REG_ADDR_LEN-1:0] dest_reg, dest_next;
    logic [WORD_LEN-1:0]     addr_reg, addr_next;
    logic [WORD_LEN-1:0]     hold_reg, hold_next;
    logic                    hold_valid_reg, hold_valid_next;
    logic [CNT_WIDTH-1:0]    count_reg, count_next;

    logic [WORD_LEN-1:0]     load_src;
    logic [WORD_LEN-1:0]     load_value;
    logic                    misalign;
    logic                    load_fault;
    logic                    retire;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ctrl_reg       <= STAGE_CTRL_CLEAR;
            dest_reg       <= '0;
            addr_reg       <= '0;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            count_reg      <= '0;
        end else begin
            ctrl_reg       <= ctrl_next;
            dest_reg       <= dest_next;
            addr_reg       <= addr_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            count_reg      <= count_next;
        end
    end

    // Flush beats freeze; only valid and wb_en are forced on a bubble.
    always_comb begin
        ctrl_next = ctrl_reg;
        dest_next = dest_reg;
        addr_next = addr_reg;
        if (bus.FLUSH) begin
            ctrl_next.valid = 1'b0;
            ctrl_next.wb_en = 1'b0;
        end else if (!bus.FREEZE) begin
            ctrl_next.valid     = 1'b1;
            ctrl_next.wb_en     = bus.WB_EN_IN;
            ctrl_next.mem_read  = bus.MEM_READ_EN;
            ctrl_next.size      = load_size_e'(bus.LOAD_SIZE);
            ctrl_next.is_signed = bus.LOAD_SIGNED;
            dest_next           = bus.DEST_IN;
            addr_next           = bus.ALU_RESULT;
        end
    end

    // Memory read data is only live for one cycle; latch it on the first frozen edge.
    always_comb begin
        hold_next       = hold_reg;
        hold_valid_next = hold_valid_reg;
        if (bus.FLUSH || !bus.FREEZE) begin
            hold_valid_next = 1'b0;
        end else if (!hold_valid_reg) begin
            hold_next       = bus.DATA_MEMORY_OUT;
            hold_valid_next = 1'b1;
        end
    end

    assign load_src = hold_valid_reg ? hold_reg : bus.DATA_MEMORY_OUT;

    wb_stage_load_align #(
        .WORD_LEN (WORD_LEN)
    ) u_load_align (
        .data      (load_src),
        .off       (addr_reg[1:0]),
        .size      (ctrl_reg.size),
        .is_signed (ctrl_reg.is_signed),
        .value     (load_value),
        .misalign  (misalign)
    );

    assign load_fault = ctrl_reg.valid & ctrl_reg.mem_read & misalign;
    assign retire     = ctrl_reg.valid & ~load_fault & ~bus.FREEZE & ~bus.FLUSH;

    always_comb begin
        count_next = count_reg;
        if (retire) begin
            count_next = count_reg + 1'b1;
        end
    end

    // R0 is hardwired to zero, so a write to it is suppressed rather than issued.
    assign bus.WB_EN         = ctrl_reg.valid & ctrl_reg.wb_en & ~load_fault & (dest_reg != '0);
    assign bus.WB_DEST       = dest_reg;
    assign bus.WB_VALUE      = ctrl_reg.mem_read ? load_value : addr_reg;
    assign bus.LOAD_FAULT    = load_fault;
    assign bus.RETIRED_COUNT = count_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; a second instance with a 3-bit
// counter exercises counter wrap-around.
module tb_wb_stage;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    wb_stage_if #(.WORD_LEN(32), .REG_ADDR_LEN(5), .CNT_WIDTH(32)) bus ();
    wb_stage_if #(.WORD_LEN(32), .REG_ADDR_LEN(5), .CNT_WIDTH(3))  bus3 ();

    wb_stage #(.WORD_LEN(32), .REG_ADDR_LEN(5), .CNT_WIDTH(32)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    wb_stage #(.WORD_LEN(32), .REG_ADDR_LEN(5), .CNT_WIDTH(3)) dut3 (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus3)
    );

    assign bus3.FREEZE          = bus.FREEZE;
    assign bus3.FLUSH           = bus.FLUSH;
    assign bus3.WB_EN_IN        = bus.WB_EN_IN;
    assign bus3.MEM_READ_EN     = bus.MEM_READ_EN;
    assign bus3.LOAD_SIZE       = bus.LOAD_SIZE;
    assign bus3.LOAD_SIGNED     = bus.LOAD_SIGNED;
    assign bus3.DEST_IN         = bus.DEST_IN;
    assign bus3.ALU_RESULT      = bus.ALU_RESULT;
    assign bus3.DATA_MEMORY_OUT = bus.DATA_MEMORY_OUT;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_op(input logic wb_en, input logic mem_read, input logic [1:0] size,
                            input logic sgn, input logic [4:0] dest, input logic [31:0] addr);
        bus.WB_EN_IN    = wb_en;
        bus.MEM_READ_EN = mem_read;
        bus.LOAD_SIZE   = size;
        bus.LOAD_SIGNED = sgn;
        bus.DEST_IN     = dest;
        bus.ALU_RESULT  = addr;
    endtask

    task automatic drive_nop();
        drive_op(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0);
        bus.FREEZE = 1'b0;
        bus.FLUSH  = 1'b0;
    endtask

    // Short asynchronous pulse placed between clock edges.
    task automatic do_reset();
        drive_nop();
        RESET = 1'b0;
        #2;
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        drive_op(1'b1, 1'b0, 2'b00, 1'b0, 5'd3, 32'hAAAA_5555);
        bus.FREEZE = 1'b0;
        bus.FLUSH  = 1'b0;
        bus.DATA_MEMORY_OUT = 32'h0;
        #3;
        checks++;
        if (bus.WB_EN !== 1'b0 || bus.WB_VALUE !== 32'h0 || bus.WB_DEST !== 5'd0 ||
            bus.LOAD_FAULT !== 1'b0 || bus.RETIRED_COUNT !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: en=%b val=%h dest=%0d fault=%b cnt=%0d, required all 0",
                     bus.WB_EN, bus.WB_VALUE, bus.WB_DEST, bus.LOAD_FAULT, bus.RETIRED_COUNT);
        end
        RESET = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.WB_EN !== 1'b1 || bus.RETIRED_COUNT !== 32'd1) begin
            errors++;
            $display("FAIL reset_prestate: en=%b cnt=%0d, required en=1 cnt=1", bus.WB_EN, bus.RETIRED_COUNT);
        end
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if (bus.WB_EN !== 1'b0 || bus.WB_VALUE !== 32'h0 || bus.RETIRED_COUNT !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: en=%b val=%h cnt=%0d, required 0/0/0",
                     bus.WB_EN, bus.WB_VALUE, bus.RETIRED_COUNT);
        end
        RESET = 1'b1;
        $display("test_reset done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_alu();
        do_reset();
        drive_op(1'b1, 1'b0, 2'b00, 1'b0, 5'd5, 32'h1234_5678);
        tick();
        checks++;
        if (bus.WB_EN !== 1'b1 || bus.WB_DEST !== 5'd5 || bus.WB_VALUE !== 32'h1234_5678 ||
            bus.LOAD_FAULT !== 1'b0) begin
            errors++;
            $display("FAIL alu_write: en=%b dest=%0d val=%h fault=%b, required 1/5/12345678/0",
                     bus.WB_EN, bus.WB_DEST, bus.WB_VALUE, bus.LOAD_FAULT);
        end
        drive_nop();
        tick();
        checks++;
        if (bus.RETIRED_COUNT !== 32'd1 || bus.WB_EN !== 1'b0) begin
            errors++;
            $display("FAIL alu_retire: cnt=%0d en=%b, required cnt=1 en=0", bus.RETIRED_COUNT, bus.WB_EN);
        end
        $display("test_alu done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_loads();
        do_reset();
        drive_op(1'b1, 1'b1, 2'b10, 1'b1, 5'd7, 32'h0000_0103);
        tick();
        bus.DATA_MEMORY_OUT = 32'h80FF_0011;
        drive_op(1'b1, 1'b1, 2'b10, 1'b0, 5'd7, 32'h0000_0103);
        #1;
        checks++;
        if (bus.WB_VALUE !== 32'hFFFF_FF80 || bus.WB_EN !== 1'b1) begin
            errors++;
            $display("FAIL byte_signed: val=%h en=%b, required ffffff80/1", bus.WB_VALUE, bus.WB_EN);
        end
        tick();
        drive_op(1'b1, 1'b1, 2'b01, 1'b1, 5'd8, 32'h0000_0102);
        checks++;
        if (bus.WB_VALUE !== 32'h0000_0080) begin
            errors++;
            $display("FAIL byte_unsigned: val=%h, required 00000080", bus.WB_VALUE);
        end
        tick();
        drive_op(1'b1, 1'b1, 2'b01, 1'b0, 5'd9, 32'h0000_0100);
        checks++;
        if (bus.WB_VALUE !== 32'hFFFF_80FF || bus.LOAD_FAULT !== 1'b0 || bus.RETIRED_COUNT !== 32'd2) begin
            errors++;
            $display("FAIL half_signed: val=%h fault=%b cnt=%0d, required ffff80ff/0/2",
                     bus.WB_VALUE, bus.LOAD_FAULT, bus.RETIRED_COUNT);
        end
        tick();
        drive_nop();
        checks++;
        if (bus.WB_VALUE !== 32'h0000_0011 || bus.WB_DEST !== 5'd9) begin
            errors++;
            $display("FAIL half_unsigned: val=%h dest=%0d, required 00000011/9", bus.WB_VALUE, bus.WB_DEST);
        end
        $display("test_loads done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_freeze();
        do_reset();
        drive_op(1'b1, 1'b1, 2'b00, 1'b0, 5'd9, 32'h0000_0200);
        tick();
        bus.DATA_MEMORY_OUT = 32'hCAFE_F00D;
        bus.FREEZE = 1'b1;
        drive_op(1'b1, 1'b0, 2'b00, 1'b0, 5'd10, 32'h0000_0055);
        #1;
        checks++;
        if (bus.WB_VALUE !== 32'hCAFE_F00D || bus.WB_DEST !== 5'd9) begin
            errors++;
            $display("FAIL freeze_entry: val=%h dest=%0d, required cafef00d/9", bus.WB_VALUE, bus.WB_DEST);
        end
        tick();
        bus.DATA_MEMORY_OUT = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (bus.WB_VALUE !== 32'hCAFE_F00D || bus.WB_EN !== 1'b1 || bus.RETIRED_COUNT !== 32'd0) begin
                errors++;
                $display("FAIL freeze_hold[%0d]: val=%h en=%b cnt=%0d, required cafef00d/1/0",
                         i, bus.WB_VALUE, bus.WB_EN, bus.RETIRED_COUNT);
            end
            tick();
        end
        checks++;
        if (bus.WB_VALUE !== 32'hCAFE_F00D || bus.RETIRED_COUNT !== 32'd0) begin
            errors++;
            $display("FAIL freeze_hold_last: val=%h cnt=%0d, required cafef00d/0", bus.WB_VALUE, bus.RETIRED_COUNT);
        end
        bus.FREEZE = 1'b0;
        tick();
        checks++;
        if (bus.RETIRED_COUNT !== 32'd1 || bus.WB_VALUE !== 32'h0000_0055 || bus.WB_DEST !== 5'd10) begin
            errors++;
            $display("FAIL freeze_release: cnt=%0d val=%h dest=%0d, required 1/00000055/10",
                     bus.RETIRED_COUNT, bus.WB_VALUE, bus.WB_DEST);
        end
        drive_nop();
        $display("test_freeze done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_fault_r0();
        do_reset();
        drive_op(1'b1, 1'b1, 2'b00, 1'b0, 5'd4, 32'h0000_0202);
        tick();
        bus.DATA_MEMORY_OUT = 32'h0102_0304;
        drive_op(1'b1, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0000_0077);
        #1;
        checks++;
        if (bus.LOAD_FAULT !== 1'b1 || bus.WB_EN !== 1'b0) begin
            errors++;
            $display("FAIL word_misalign: fault=%b en=%b, required 1/0", bus.LOAD_FAULT, bus.WB_EN);
        end
        tick();
        drive_op(1'b1, 1'b1, 2'b01, 1'b0, 5'd6, 32'h0000_0301);
        checks++;
        if (bus.RETIRED_COUNT !== 32'd0 || bus.WB_EN !== 1'b0 || bus.LOAD_FAULT !== 1'b0 ||
            bus.WB_VALUE !== 32'h0000_0077) begin
            errors++;
            $display("FAIL r0_write: cnt=%0d en=%b fault=%b val=%h, required 0/0/0/00000077",
                     bus.RETIRED_COUNT, bus.WB_EN, bus.LOAD_FAULT, bus.WB_VALUE);
        end
        tick();
        drive_nop();
        checks++;
        if (bus.RETIRED_COUNT !== 32'd1 || bus.LOAD_FAULT !== 1'b1 || bus.WB_EN !== 1'b0) begin
            errors++;
            $display("FAIL half_misalign: cnt=%0d fault=%b en=%b, required 1/1/0",
                     bus.RETIRED_COUNT, bus.LOAD_FAULT, bus.WB_EN);
        end
        tick();
        checks++;
        if (bus.RETIRED_COUNT !== 32'd1) begin
            errors++;
            $display("FAIL fault_nocount: cnt=%0d, required 1", bus.RETIRED_COUNT);
        end
        $display("test_fault_r0 done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_flush_freeze();
        do_reset();
        drive_op(1'b1, 1'b0, 2'b00, 1'b0, 5'd6, 32'h0000_0099);
        tick();
        bus.FLUSH  = 1'b1;
        bus.FREEZE = 1'b1;
        tick();
        checks++;
        if (bus.WB_EN !== 1'b0 || bus.RETIRED_COUNT !== 32'd0) begin
            errors++;
            $display("FAIL flush_freeze: en=%b cnt=%0d, required 0/0", bus.WB_EN, bus.RETIRED_COUNT);
        end
        drive_nop();
        tick();
        checks++;
        if (bus.RETIRED_COUNT !== 32'd0) begin
            errors++;
            $display("FAIL bubble_nocount: cnt=%0d, required 0", bus.RETIRED_COUNT);
        end
        $display("test_flush_freeze done checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_op(1'b1, 1'b0, 2'b00, 1'b0, 5'(i + 1), 32'(i));
            tick();
        end
        checks++;
        if (bus3.RETIRED_COUNT !== 3'd7 || bus.RETIRED_COUNT !== 32'd7) begin
            errors++;
            $display("FAIL wrap_pre: cnt3=%0d cnt=%0d, required 7/7", bus3.RETIRED_COUNT, bus.RETIRED_COUNT);
        end
        drive_nop();
        tick();
        checks++;
        if (bus3.RETIRED_COUNT !== 3'd0 || bus.RETIRED_COUNT !== 32'd8) begin
            errors++;
            $display("FAIL wrap: cnt3=%0d cnt=%0d, required 0/8", bus3.RETIRED_COUNT, bus.RETIRED_COUNT);
        end
        $display("test_wrap done checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu();
        test_loads();
        test_freeze();
        test_fault_r0();
        test_flush_freeze();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
